// File: rtl/rx_combine_pkg.sv
// Shared definitions for the combine user scheduler: sizes, FSM encoding, and the
// layout of one config table entry.
package rx_combine_pkg;

    localparam int unsigned MAX_USERS = 16;
    localparam int unsigned QM_W      = 2;
    localparam int unsigned IDX_W     = 4;
    localparam int unsigned E01_W     = 14;
    localparam int unsigned NCB_W     = 16;

    typedef enum logic [5:0] {
        StIdle = 6'b000001,
        StLoad = 6'b000010,
        StReq  = 6'b000100,
        StRun  = 6'b001000,
        StNext = 6'b010000,
        StDone = 6'b100000
    } sched_state_e;

    typedef struct packed {
        logic [QM_W-1:0]  qm;
        logic [NCB_W-1:0] ncb;
        logic [E01_W-1:0] e01;
    } cfg_entry_t;

endpackage

// File: rtl/combine_cfg_table.sv
// Per-user config register file: one synchronous write port, asynchronous read of
// the addressed entry, and every entry's qm code exposed in parallel.
module combine_cfg_table
    import rx_combine_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we,
    input  logic [IDX_W-1:0]          waddr,
    input  cfg_entry_t                wdata,
    input  logic [IDX_W-1:0]          raddr,
    output logic [E01_W-1:0]          rd_e01,
    output logic [NCB_W-1:0]          rd_ncb,
    output logic [MAX_USERS*QM_W-1:0] qm_all
);

    cfg_entry_t mem [MAX_USERS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_USERS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rd_e01 = mem[raddr].e01;
    assign rd_ncb = mem[raddr].ncb;

    always_comb begin
        qm_all = '0;
        for (int i = 0; i < MAX_USERS; i++) begin
            qm_all[i*QM_W +: QM_W] = mem[i].qm;
        end
    end

endmodule

// File: rtl/combine_user_scheduler.sv
// Walks the configured users of one combine pass, issuing one RDM request per
// non-empty user and waiting for completion under a watchdog.
module combine_user_scheduler #(
    parameter int unsigned MAX_USERS      = rx_combine_pkg::MAX_USERS,
    parameter int unsigned TIMEOUT_CYCLES = 20'hFFFFF
) (
    input  logic        i_core_clk,
    input  logic        i_rx_rst,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic [4:0]  i_user_num,
    input  logic        i_cfg_we,
    input  logic [3:0]  i_cfg_user,
    input  logic [13:0] i_cfg_e01,
    input  logic [15:0] i_cfg_ncb,
    input  logic [1:0]  i_cfg_qm,
    input  logic        i_RDM_Data_Comp,
    output logic        o_Combine_process_request,
    output logic [3:0]  o_Combine_user_index,
    output logic [13:0] o_Current_Combine_E01_Size,
    output logic [15:0] o_Current_Combine_Ncb_Size,
    output logic [31:0] o_users_qm,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_timeout
);

    import rx_combine_pkg::*;

    localparam logic [20:0] TimeoutLim = 21'(TIMEOUT_CYCLES);

    sched_state_e state_q, state_d;
    logic [3:0]   idx_q, idx_d;
    logic [4:0]   cnt_q, cnt_d;
    logic [19:0]  wd_q, wd_d;
    logic         timeout_q, timeout_d;
    logic         req_q, done_q, load_en;
    logic [3:0]   out_idx_q;
    logic [13:0]  e01_q, rd_e01;
    logic [15:0]  ncb_q, rd_ncb;
    logic [4:0]   num_sat;
    logic         busy;
    cfg_entry_t   cfg_wdata;

    assign busy      = (state_q != StIdle);
    assign num_sat   = (i_user_num > 5'(MAX_USERS)) ? 5'(MAX_USERS) : i_user_num;
    assign cfg_wdata = '{qm: i_cfg_qm, ncb: i_cfg_ncb, e01: i_cfg_e01};

    combine_cfg_table u_cfg_table (
        .clk    (i_core_clk),
        .rst    (i_rx_rst),
        .we     (i_cfg_we & ~busy),
        .waddr  (i_cfg_user),
        .wdata  (cfg_wdata),
        .raddr  (idx_q),
        .rd_e01 (rd_e01),
        .rd_ncb (rd_ncb),
        .qm_all (o_users_qm)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        wd_d      = wd_q;
        timeout_d = timeout_q;
        load_en   = 1'b0;
        if (i_abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_start) begin
                        timeout_d = 1'b0;
                        if (num_sat == 5'd0) begin
                            state_d = StDone;
                        end else begin
                            idx_d   = '0;
                            cnt_d   = num_sat;
                            state_d = StLoad;
                        end
                    end
                end
                StLoad: begin
                    load_en = 1'b1;
                    state_d = (rd_e01 == '0) ? StNext : StReq;
                end
                StReq: begin
                    wd_d    = '0;
                    state_d = StRun;
                end
                StRun: begin
                    // Completion is checked first so it wins a same-cycle timeout.
                    if (i_RDM_Data_Comp) begin
                        state_d = StNext;
                    end else if ((21'(wd_q) + 21'd1) >= TimeoutLim) begin
                        timeout_d = 1'b1;
                        state_d   = StNext;
                    end else begin
                        wd_d = wd_q + 20'd1;
                    end
                end
                StNext: begin
                    if ({1'b0, idx_q} == (cnt_q - 5'd1)) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = StLoad;
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
        if (i_rx_rst) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            cnt_q     <= '0;
            wd_q      <= '0;
            timeout_q <= 1'b0;
            req_q     <= 1'b0;
            done_q    <= 1'b0;
            out_idx_q <= '0;
            e01_q     <= '0;
            ncb_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
            req_q     <= (state_q == StReq) && !i_abort;
            done_q    <= (state_q == StDone) && !i_abort;
            if (load_en) begin
                out_idx_q <= idx_q;
                e01_q     <= rd_e01;
                ncb_q     <= rd_ncb;
            end
        end
    end

    assign o_Combine_process_request  = req_q;
    assign o_Combine_user_index       = out_idx_q;
    assign o_Current_Combine_E01_Size = e01_q;
    assign o_Current_Combine_Ncb_Size = ncb_q;
    assign o_busy                     = busy;
    assign o_done                     = done_q;
    assign o_timeout                  = timeout_q;

endmodule

// File: tb/tb_combine_user_scheduler.sv
// Scoreboard bench: expected request/done events are queued as each pass is launched
// and popped by a negedge monitor as the scheduler emits them.
module tb_combine_user_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, abort = 1'b0, cfg_we = 1'b0, comp = 1'b0;
    logic [4:0]  user_num = '0;
    logic [3:0]  cfg_user = '0;
    logic [13:0] cfg_e01 = '0;
    logic [15:0] cfg_ncb = '0;
    logic [1:0]  cfg_qm = '0;
    logic        req, busy, done, tmo;
    logic [3:0]  idx;
    logic [13:0] e01;
    logic [15:0] ncb;
    logic [31:0] qm;

    int n_cmp = 0;
    int n_err = 0;
    bit resp_en = 1'b1;

    typedef struct {
        int kind;  // 0 = request, 1 = done
        int idx;
        int e01;
        int ncb;
    } ev_t;
    ev_t sb[$];

    always #5 clk = ~clk;

    combine_user_scheduler #(
        .MAX_USERS      (16),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .i_core_clk                 (clk),
        .i_rx_rst                   (rst),
        .i_start                    (start),
        .i_abort                    (abort),
        .i_user_num                 (user_num),
        .i_cfg_we                   (cfg_we),
        .i_cfg_user                 (cfg_user),
        .i_cfg_e01                  (cfg_e01),
        .i_cfg_ncb                  (cfg_ncb),
        .i_cfg_qm                   (cfg_qm),
        .i_RDM_Data_Comp            (comp),
        .o_Combine_process_request  (req),
        .o_Combine_user_index       (idx),
        .o_Current_Combine_E01_Size (e01),
        .o_Current_Combine_Ncb_Size (ncb),
        .o_users_qm                 (qm),
        .o_busy                     (busy),
        .o_done                     (done),
        .o_timeout                  (tmo)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_req(input int i);
        sb.push_back('{kind: 0, idx: i, e01: 96, ncb: 128});
    endtask

    task automatic push_done();
        sb.push_back('{kind: 1, idx: 0, e01: 0, ncb: 0});
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (req) begin
            if (sb.size() == 0) begin
                check("unexp_req", 32'(req), 32'd0);
            end else begin
                e = sb.pop_front();
                check("req_kind", 32'd0, 32'(e.kind));
                check("req_idx", 32'(idx), 32'(e.idx));
                check("req_e01", 32'(e01), 32'(e.e01));
                check("req_ncb", 32'(ncb), 32'(e.ncb));
            end
        end
        if (done) begin
            if (sb.size() == 0) begin
                check("unexp_done", 32'(done), 32'd0);
            end else begin
                e = sb.pop_front();
                check("done_kind", 32'd1, 32'(e.kind));
            end
        end
    end

    // RDM model: completes 10 cycles after each request when enabled.
    initial begin
        forever begin
            @(negedge clk);
            if (req && resp_en) begin
                repeat (9) @(negedge clk);
                comp = 1'b1;
                @(negedge clk);
                comp = 1'b0;
            end
        end
    end

    task automatic cfg_write(input logic [3:0] u, input logic [13:0] e, input logic [15:0] n,
                             input logic [1:0] q);
        @(negedge clk);
        cfg_we = 1'b1; cfg_user = u; cfg_e01 = e; cfg_ncb = n; cfg_qm = q;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Returns #1 after the edge that samples the start pulse.
    task automatic start_pass(input logic [4:0] num);
        @(negedge clk);
        user_num = num; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (n < budget) begin
            @(posedge clk); #1;
            if (done) break;
            n++;
        end
        if (n >= budget) check("done_wait", 32'(done), 32'd1);
    endtask

    task automatic settle();
        repeat (30) @(negedge clk);
    endtask

    initial begin
        int n;
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req", 32'(req), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_tmo", 32'(tmo), 32'd0);
        check("rst_e01", 32'(e01), 32'd0);
        check("rst_qm", qm, 32'd0);
        rst = 1'b0;

        // Three users, each completed 10 cycles after its request
        for (int u = 0; u < 3; u++) cfg_write(4'(u), 14'd96, 16'd128, 2'(u + 1));
        check("qm_pack", qm, 32'h39);
        push_req(0); push_req(1); push_req(2); push_done();
        start_pass(5'd3);
        n = 1;
        while (!req && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("req_lat", 32'(n), 32'd3);
        wait_done(300);
        check("t1_tmo", 32'(tmo), 32'd0);
        settle();

        // Empty user is skipped
        cfg_write(4'd1, 14'd0, 16'd128, 2'd2);
        push_req(0); push_req(2); push_done();
        start_pass(5'd3);
        wait_done(300);
        settle();

        // Oversized user count saturates to the table depth
        push_req(0); push_req(2); push_done();
        start_pass(5'd20);
        wait_done(600);
        settle();

        // Zero users: done without a request
        push_done();
        start_pass(5'd0);
        n = 1;
        while (!done && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_lat", 32'(n), 32'd2);
        settle();

        // Watchdog: no completion
        resp_en = 1'b0;
        push_req(0); push_done();
        start_pass(5'd1);
        n = 0;
        while (!req && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        n = 0;
        while (!tmo && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("tmo_cycles", 32'(n), 32'd50);
        wait_done(20);
        check("tmo_sticky", 32'(tmo), 32'd1);
        settle();
        check("tmo_hold", 32'(tmo), 32'd1);
        push_done();
        start_pass(5'd0);
        check("tmo_clr", 32'(tmo), 32'd0);
        resp_en = 1'b1;
        settle();

        // Abort during user 1, with a dropped write while busy
        cfg_write(4'd1, 14'd96, 16'd128, 2'd2);
        push_req(0); push_req(1);
        start_pass(5'd3);
        n = 0;
        while (!(req && idx == 4'd1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("abort_reach", 32'(idx), 32'd1);
        cfg_write(4'd0, 14'd5, 16'd7, 2'd0);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_idle", 32'(busy), 32'd0);
        settle();
        check("abort_qm", qm, 32'h39);
        push_req(0); push_done();
        start_pass(5'd1);
        wait_done(100);
        settle();

        // Asynchronous reset while in REQ
        start_pass(5'd3);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_req", 32'(req), 32'd0);
        check("arst_idx_e01", {18'(idx), 14'(e01)}, 32'd0);
        check("arst_qm", qm, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        settle();
        check("arst_done", 32'(done), 32'd0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/combine_user_scheduler.md
COMBINE_USER_SCHEDULER -- requirements
Module: combine_user_scheduler

Interface
REQ-001 SHALL have parameter MAX_USERS, default 16, meaning the config table depth and maximum users per pass.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 20'hFFFFF, meaning the RUN watchdog limit in core clocks.
REQ-003 SHALL have port i_core_clk, input, 1, the single core clock.
REQ-004 SHALL have port i_rx_rst, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port i_start, input, 1, a pass-start pulse.
REQ-006 SHALL have port i_abort, input, 1, which aborts the current pass.
REQ-007 SHALL have port i_user_num, input, 5, the number of users in the pass (0..16).
REQ-008 SHALL have port i_cfg_we, input, 1, the config table write strobe.
REQ-009 SHALL have port i_cfg_user, input, 4, the config table write index.
REQ-010 SHALL have port i_cfg_e01, input, 14, the per-user E01 size.
REQ-011 SHALL have port i_cfg_ncb, input, 16, the per-user Ncb size.
REQ-012 SHALL have port i_cfg_qm, input, 2, the per-user modulation order code.
REQ-013 SHALL have port i_RDM_Data_Comp, input, 1, the completion flag from the RDM engine.
REQ-014 SHALL have port o_Combine_process_request, output, 1, a one-cycle request to the RDM engine.
REQ-015 SHALL have port o_Combine_user_index, output, 4, the active user.
REQ-016 SHALL have port o_Current_Combine_E01_Size, output, 14, the active user's E01 size.
REQ-017 SHALL have port o_Current_Combine_Ncb_Size, output, 16, the active user's Ncb size.
REQ-018 SHALL have port o_users_qm, output, 32, the qm codes packed 2 bits per user, user n at [2n+1:2n].
REQ-019 SHALL have port o_busy, output, 1, high when not in IDLE.
REQ-020 SHALL have port o_done, output, 1, a one-cycle pass-complete pulse.
REQ-021 SHALL have port o_timeout, output, 1, a sticky watchdog error flag.

Function
REQ-022 SHALL implement one-hot states IDLE, LOAD, REQ, RUN, NEXT, DONE.
REQ-023 Config writes SHALL be accepted only when o_busy=0; writes while busy SHALL be dropped, with no other effect.
REQ-024 In IDLE, i_start with i_user_num>0 SHALL clear the user index to 0, latch i_user_num, and move to LOAD.
REQ-025 In IDLE, i_start with i_user_num=0 SHALL move directly to DONE; values above 16 SHALL be saturated to 16.
REQ-026 In LOAD, the E01, Ncb and index outputs SHALL be registered from table[index]; an entry with E01=0 SHALL skip to NEXT without issuing a request.
REQ-027 REQ SHALL last one cycle, and o_Combine_process_request SHALL be high in exactly the cycle after REQ (registered); the state then moves to RUN.
REQ-028 When no user is skipped, the request SHALL assert exactly 3 clocks after the edge that sampled i_start.
REQ-029 RUN SHALL wait for i_RDM_Data_Comp=1, then move to NEXT; i_RDM_Data_Comp SHALL be ignored outside RUN.
REQ-030 The RUN watchdog SHALL reset on RUN entry; reaching TIMEOUT_CYCLES SHALL set o_timeout and move to NEXT.
REQ-031 If completion and timeout occur in the same cycle, completion SHALL win and o_timeout SHALL not be set.
REQ-032 In NEXT, index = latched count-1 SHALL move to DONE; otherwise the index SHALL increment and the state SHALL move to LOAD; the index SHALL never wrap.
REQ-033 DONE SHALL assert o_done for one cycle and return to IDLE.
REQ-034 i_start while busy SHALL be ignored.
REQ-035 i_abort SHALL force IDLE on the next edge from any state, SHALL win over i_start, and SHALL produce no o_done.
REQ-036 o_users_qm SHALL reflect the table continuously, changing only on accepted writes.
REQ-037 The config outputs SHALL be held stable from LOAD until the next LOAD or IDLE.
REQ-038 o_timeout SHALL be cleared only by reset or by an accepted i_start.

Reset
REQ-039 On i_rx_rst=1, the block SHALL go to IDLE and clear every output, the index, the watchdog and the table to 0, asynchronously.
REQ-040 Reset asserted mid-pass SHALL abandon the pass without emitting o_done or o_Combine_process_request.

Structure
REQ-041 State encodings, MAX_USERS and the qm field width SHALL live in the shared package rx_combine_pkg.
REQ-042 The config table SHALL be a sub-module named combine_cfg_table (16x32 register file, one write port, async read).

Verification
REQ-043 Write users 0..2 (E01=96, Ncb=128), then i_start with i_user_num=3, replying comp 10 cycles after each request -> 3 request pulses at indices 0, 1, 2, one o_done, o_timeout=0.
REQ-044 Set user 1 E01=0, then run 3 users -> requests only for indices 0 and 2, then o_done.
REQ-045 i_start with i_user_num=0 -> o_done 2 cycles later, no request.
REQ-046 With TIMEOUT_CYCLES=50 and no comp -> o_timeout=1 after 50 RUN cycles, the pass continues and o_done is pulsed.
REQ-047 i_abort during RUN of user 1 -> IDLE next cycle, no o_done; a config write while busy has no table effect.
REQ-048 Reset pulse during REQ -> all outputs 0 immediately and no request pulse.
